mem_wb_writeback: RTL and testbench
===================================

# mem_wb_writeback

Write-back stage of the pipelined MIPS datapath: the MEM/WB pipeline register plus the write-back select and load-alignment logic that drive the write port of the register file (WriteRegister, WriteData, RegWrite). It captures the MEM-stage result each cycle and presents a fully registered write request to the register file one cycle later. It also keeps a retired-instruction counter that is used as a debug signal.

## Interface
Parameters:
- DATA_W, 32, datapath width.
- REG_AW, 5, register address width.

Ports:
- Clk  in  1  pipeline clock; all state updates on the rising edge.
- Reset  in  1  synchronous, active-high reset.
- Stall  in  1  hold the MEM/WB register contents.
- Flush  in  1  replace the incoming instruction with a bubble.
- MemValid  in  1  MEM stage holds a real instruction.
- MemRegWrite  in  1  instruction writes a register.
- MemtoReg  in  1  1: load data, 0: ALU result.
- Link  in  1  jal/jalr: write PCPlus4+4 (overrides MemtoReg).
- MemWriteReg  in  REG_AW  destination register.
- ALUResult  in  DATA_W  ALU result; bits [1:0] are the byte offset for loads.
- MemReadData  in  DATA_W  raw word read from data memory.
- PCPlus4  in  DATA_W  PC+4 of the instruction.
- LoadSize  in  2  00 word, 01 half, 10 byte, 11 reserved (treated as word).
- LoadSigned  in  1  sign-extend sub-word loads.
- WriteRegister  out  REG_AW  register file write address.
- WriteData  out  DATA_W  register file write data.
- RegWrite  out  1  register file write enable.
- RetiredCount  out  32  count of valid instructions accepted into WB (mark_debug).

## Operation
- Next-state data select, in priority order: Link gives PCPlus4+4 (mod 2^32). Otherwise MemtoReg gives the aligned load value. Otherwise ALUResult.
- Load alignment uses off = ALUResult[1:0], little-endian.
  - Byte: MemReadData[8*off+7 : 8*off].
  - Half: off[1]=0 selects [15:0]; off[1]=1 selects [31:16]. off[0] is ignored.
  - Sub-word values are zero-extended to 32 bits, or sign-extended when LoadSigned=1.
- Write enable captured = MemValid & MemRegWrite & (MemWriteReg != 0). A write to $0 never reaches the register file.
- Per-edge update, in priority order:
  - Reset: RegWrite=0, WriteRegister=0, WriteData=0, RetiredCount=0.
  - Flush: RegWrite=0, WriteRegister=0, WriteData=0. RetiredCount is unchanged.
  - Stall: all outputs and the counter hold.
  - Otherwise: capture RegWrite, WriteRegister and WriteData. RetiredCount increments by 1 if MemValid=1.
- Flush takes priority over Stall. Reset takes priority over both.
- During a stall, a held RegWrite=1 repeats the same write every cycle. This is idempotent and is the required behaviour.
- RetiredCount wraps from 0xFFFFFFFF to 0.
- Bubbles (MemValid=0) are captured with RegWrite=0. WriteRegister and WriteData still load the selected values; they are don't-care.

## Timing
- Every output is a flop, with no combinational path from inputs to outputs.
- Latency is 1 cycle: inputs sampled at edge N appear at the outputs after edge N. The register file writes at edge N+1.
- The register file must write on the rising edge and read the new value in the same cycle (write-first). Without that, the decode stage needs its own forwarding path. That requirement is outside this block.
- A Reset asserted mid-stream clears everything at the next edge, regardless of Stall or Flush. The first capture happens on the edge after Reset deasserts.
- Stall and Flush are sampled at the same edge as the data.

## Test plan
- Reset: hold Reset for 2 cycles with random inputs -> RegWrite=0, WriteRegister=0, WriteData=0, RetiredCount=0. Release with an ALU op to $8 of 0x1234 -> next cycle RegWrite=1, WriteRegister=8, WriteData=0x00001234, RetiredCount=1.
- Loads: MemReadData=0x80FF7F01 with MemtoReg=1.
  - Byte, signed, off=3 -> 0xFFFFFF80.
  - Byte, unsigned, off=1 -> 0x0000007F.
  - Half, signed, off=2 -> 0xFFFF80FF.
  - Half, unsigned, off=0 -> 0x00007F01.
  - Word -> 0x80FF7F01.
- Link and $0:
  - Link=1, PCPlus4=0x00400010, MemWriteReg=31 -> WriteData=0x00400014, RegWrite=1.
  - Same instruction with MemWriteReg=0 -> RegWrite=0, and RetiredCount still increments.
- Stall and flush:
  - Stall for 3 cycles -> outputs and RetiredCount hold.
  - Stall and Flush together -> RegWrite=0 next cycle, RetiredCount unchanged.
  - Flush with MemValid=1 -> instruction dropped, count unchanged.
- Counter wrap: preload via 2^32-1 accepted instructions (or force RetiredCount=0xFFFFFFFF), then one more valid capture -> 0x00000000.
- Back-to-back stream of 100 random instructions checked against a reference model -> every output matches with exactly 1-cycle latency.

Source files
------------

// File: rtl/mem_wb_writeback.sv
`default_nettype none
// ============================================================================
// Module      : mem_wb_writeback
// Description : MEM/WB pipeline register with write-back select and load
//               alignment; drives the register-file write port.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_wb_writeback #(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              Stall,
    input  logic              Flush,
    input  logic              MemValid,
    input  logic              MemRegWrite,
    input  logic              MemtoReg,
    input  logic              Link,
    input  logic [REG_AW-1:0] MemWriteReg,
    input  logic [DATA_W-1:0] ALUResult,
    input  logic [DATA_W-1:0] MemReadData,
    input  logic [DATA_W-1:0] PCPlus4,
    input  logic [1:0]        LoadSize,
    input  logic              LoadSigned,
    output logic [REG_AW-1:0] WriteRegister,
    output logic [DATA_W-1:0] WriteData,
    output logic              RegWrite,
    output logic [31:0]       RetiredCount
);

    localparam logic [1:0]        c_size_half = 2'b01;
    localparam logic [1:0]        c_size_byte = 2'b10;
    localparam logic [DATA_W-1:0] c_link_ofs  = DATA_W'(4);

    logic [1:0]        w_off;
    logic [7:0]        w_byte;
    logic [15:0]       w_half;
    logic [DATA_W-1:0] w_load_data;
    logic [DATA_W-1:0] w_next_data;
    logic              w_write_en;

    logic [REG_AW-1:0] r_write_register;
    logic [DATA_W-1:0] r_write_data;
    logic              r_reg_write;
    logic [31:0]       r_retired_count;

    assign w_off = ALUResult[1:0];

    // Little-endian lane selection; half-word loads ignore off[0].
    always_comb begin
        w_byte = MemReadData[7:0];
        case (w_off)
            2'd0:    w_byte = MemReadData[7:0];
            2'd1:    w_byte = MemReadData[15:8];
            2'd2:    w_byte = MemReadData[23:16];
            default: w_byte = MemReadData[31:24];
        endcase
    end

    assign w_half = w_off[1] ? MemReadData[31:16] : MemReadData[15:0];

    always_comb begin
        w_load_data = MemReadData;
        case (LoadSize)
            c_size_half: w_load_data = {{(DATA_W-16){LoadSigned & w_half[15]}}, w_half};
            c_size_byte: w_load_data = {{(DATA_W-8){LoadSigned & w_byte[7]}}, w_byte};
            default:     w_load_data = MemReadData;
        endcase
    end

    always_comb begin
        w_next_data = ALUResult;
        if (Link) begin
            w_next_data = PCPlus4 + c_link_ofs;
        end else if (MemtoReg) begin
            w_next_data = w_load_data;
        end
    end

    // Register $0 is hard-wired to zero, so it is never written.
    assign w_write_en = MemValid & MemRegWrite & (MemWriteReg != '0);

    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_reg_write      <= 1'b0;
            r_write_register <= '0;
            r_write_data     <= '0;
            r_retired_count  <= '0;
        end else if (Flush) begin
            r_reg_write      <= 1'b0;
            r_write_register <= '0;
            r_write_data     <= '0;
        end else if (!Stall) begin
            r_reg_write      <= w_write_en;
            r_write_register <= MemWriteReg;
            r_write_data     <= w_next_data;
            r_retired_count  <= r_retired_count + {31'd0, MemValid};
        end
    end

    assign RegWrite      = r_reg_write;
    assign WriteRegister = r_write_register;
    assign WriteData     = r_write_data;
    assign RetiredCount  = r_retired_count;

endmodule
`default_nettype wire

// File: tb/tb_mem_wb_writeback.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_wb_writeback
// Description : Scoreboard bench for mem_wb_writeback; stimulus pushes the
//               expected response, a monitor pops and compares each cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_wb_writeback;

    logic        Clk = 1'b0;
    logic        Reset, Stall, Flush, MemValid, MemRegWrite, MemtoReg, Link;
    logic [4:0]  MemWriteReg;
    logic [31:0] ALUResult, MemReadData, PCPlus4;
    logic [1:0]  LoadSize;
    logic        LoadSigned;
    logic [4:0]  WriteRegister;
    logic [31:0] WriteData;
    logic        RegWrite;
    logic [31:0] RetiredCount;

    always #5 Clk = ~Clk;

    mem_wb_writeback #(.DATA_W(32), .REG_AW(5)) dut (
        .Clk(Clk), .Reset(Reset), .Stall(Stall), .Flush(Flush),
        .MemValid(MemValid), .MemRegWrite(MemRegWrite), .MemtoReg(MemtoReg),
        .Link(Link), .MemWriteReg(MemWriteReg), .ALUResult(ALUResult),
        .MemReadData(MemReadData), .PCPlus4(PCPlus4), .LoadSize(LoadSize),
        .LoadSigned(LoadSigned), .WriteRegister(WriteRegister),
        .WriteData(WriteData), .RegWrite(RegWrite), .RetiredCount(RetiredCount)
    );

    typedef struct {
        logic        rw;
        logic [4:0]  wr;
        logic [31:0] wd;
        logic [31:0] cnt;
        bit          chk_data;
        string       name;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    bit   done   = 0;

    // Reference state of the registered outputs.
    logic        m_rw  = 0;
    logic [4:0]  m_wr  = 0;
    logic [31:0] m_wd  = 0;
    logic [31:0] m_cnt = 0;
    bit          m_chk = 1;

    function automatic logic [31:0] model_data();
        logic [31:0] sh;
        logic [31:0] r;
        if (Link) return PCPlus4 + 32'd4;
        if (!MemtoReg) return ALUResult;
        if (LoadSize == 2'b10) begin
            sh = MemReadData >> (8 * ALUResult[1:0]);
            r  = sh & 32'hFF;
            if (LoadSigned && sh[7]) r = r | 32'hFFFFFF00;
            return r;
        end
        if (LoadSize == 2'b01) begin
            sh = MemReadData >> (16 * ALUResult[1]);
            r  = sh & 32'hFFFF;
            if (LoadSigned && sh[15]) r = r | 32'hFFFF0000;
            return r;
        end
        return MemReadData;
    endfunction

    // Called at a negedge with inputs already driven; hand_wd overrides the model.
    task automatic step(input string name, input bit use_hand = 0, input logic [31:0] hand_wd = 0);
        exp_t e;
        if (Reset) begin
            m_rw = 0; m_wr = 0; m_wd = 0; m_cnt = 0; m_chk = 1;
        end else if (Flush) begin
            m_rw = 0; m_wr = 0; m_wd = 0; m_chk = 1;
        end else if (!Stall) begin
            m_rw  = MemValid & MemRegWrite & (MemWriteReg != 0);
            m_wr  = MemWriteReg;
            m_wd  = use_hand ? hand_wd : model_data();
            m_cnt = m_cnt + (MemValid ? 32'd1 : 32'd0);
            m_chk = m_rw;
        end
        e.rw = m_rw; e.wr = m_wr; e.wd = m_wd; e.cnt = m_cnt;
        e.chk_data = m_chk; e.name = name;
        exp_q.push_back(e);
        @(negedge Clk);
    endtask

    task automatic idle_inputs();
        Reset = 0; Stall = 0; Flush = 0; MemValid = 0; MemRegWrite = 0;
        MemtoReg = 0; Link = 0; MemWriteReg = 0; ALUResult = 0;
        MemReadData = 0; PCPlus4 = 0; LoadSize = 0; LoadSigned = 0;
    endtask

    task automatic instr(input logic [4:0] wr, input logic m2r, input logic lnk,
                         input logic [31:0] alu, input logic [1:0] sz, input logic sgn);
        Reset = 0; Stall = 0; Flush = 0; MemValid = 1; MemRegWrite = 1;
        MemWriteReg = wr; MemtoReg = m2r; Link = lnk; ALUResult = alu;
        LoadSize = sz; LoadSigned = sgn;
    endtask

    task automatic randomize_inputs();
        MemValid    = 1'($urandom);
        MemRegWrite = 1'($urandom);
        MemtoReg    = 1'($urandom);
        Link        = ($urandom_range(0, 5) == 0);
        MemWriteReg = 5'($urandom);
        ALUResult   = $urandom;
        MemReadData = $urandom;
        PCPlus4     = $urandom;
        LoadSize    = 2'($urandom);
        LoadSigned  = 1'($urandom);
    endtask

    // Monitor: outputs are registered, so compare 1 time unit after each edge.
    always @(posedge Clk) begin
        exp_t e;
        #1;
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            checks++;
            if (RegWrite !== e.rw || WriteRegister !== e.wr || RetiredCount !== e.cnt ||
                (e.chk_data && WriteData !== e.wd)) begin
                errors++;
                $display("FAIL %s: got rw=%0b wr=%0d wd=%h cnt=%h, expected rw=%0b wr=%0d wd=%h%s cnt=%h",
                         e.name, RegWrite, WriteRegister, WriteData, RetiredCount,
                         e.rw, e.wr, e.wd, e.chk_data ? "" : "(dc)", e.cnt);
            end
        end
    end

    initial begin
        idle_inputs();
        @(negedge Clk);

        // Reset with random inputs
        Reset = 1; randomize_inputs(); Stall = 1'($urandom); Flush = 1'($urandom);
        step("reset0");
        randomize_inputs();
        step("reset1");
        instr(5'd8, 0, 0, 32'h0000_1234, 2'b00, 0);
        step("alu_first", 1, 32'h0000_1234);

        // Load alignment
        MemReadData = 32'h80FF_7F01;
        instr(5'd9, 1, 0, 32'h1000_0003, 2'b10, 1); step("lb_off3",  1, 32'hFFFF_FF80);
        instr(5'd9, 1, 0, 32'h1000_0001, 2'b10, 0); step("lbu_off1", 1, 32'h0000_007F);
        instr(5'd9, 1, 0, 32'h1000_0002, 2'b10, 1); step("lb_off2",  1, 32'hFFFF_FFFF);
        instr(5'd9, 1, 0, 32'h1000_0000, 2'b10, 1); step("lb_off0",  1, 32'h0000_0001);
        instr(5'd9, 1, 0, 32'h1000_0002, 2'b01, 1); step("lh_off2",  1, 32'hFFFF_80FF);
        instr(5'd9, 1, 0, 32'h1000_0000, 2'b01, 0); step("lhu_off0", 1, 32'h0000_7F01);
        instr(5'd9, 1, 0, 32'h1000_0003, 2'b01, 0); step("lhu_off3", 1, 32'h0000_80FF);
        instr(5'd9, 1, 0, 32'h1000_0000, 2'b00, 1); step("lw",       1, 32'h80FF_7F01);
        instr(5'd9, 1, 0, 32'h1000_0003, 2'b11, 0); step("lw_rsvd",  1, 32'h80FF_7F01);

        // Link and $0
        PCPlus4 = 32'h0040_0010;
        instr(5'd31, 1, 1, 32'h1000_0000, 2'b00, 0); step("jal",      1, 32'h0040_0014);
        instr(5'd0,  1, 1, 32'h1000_0000, 2'b00, 0); step("jal_zero", 1, 32'h0040_0014);
        PCPlus4 = 32'hFFFF_FFFC;
        instr(5'd31, 0, 1, 32'h0, 2'b00, 0);         step("jal_wrap", 1, 32'h0000_0000);

        // Stall holds outputs even while inputs change
        instr(5'd12, 0, 0, 32'hCAFE_0001, 2'b00, 0); step("pre_stall", 1, 32'hCAFE_0001);
        for (int i = 0; i < 3; i++) begin
            instr(5'd13, 0, 0, 32'hDEAD_0000 + 32'(i), 2'b00, 0);
            Stall = 1;
            step("stall_hold");
        end
        Stall = 1; Flush = 1; step("stall_flush");
        Stall = 0; Flush = 1; step("flush_valid");
        instr(5'd14, 0, 0, 32'h0000_0BEE, 2'b00, 0); step("post_flush", 1, 32'h0000_0BEE);

        // Bubble: no write, no count
        idle_inputs(); MemRegWrite = 1; MemWriteReg = 5'd3; step("bubble");

        // Counter wrap
        force dut.r_retired_count = 32'hFFFF_FFFF;
        #1;
        release dut.r_retired_count;
        m_cnt = 32'hFFFF_FFFF;
        instr(5'd15, 0, 0, 32'h0000_0055, 2'b00, 0); step("cnt_wrap", 1, 32'h0000_0055);

        // Mid-stream reset beats stall/flush
        instr(5'd16, 0, 0, 32'h1, 2'b00, 0); Reset = 1; Stall = 1; Flush = 1;
        step("reset_mid");
        instr(5'd17, 0, 0, 32'h0000_0777, 2'b00, 0); step("after_reset", 1, 32'h0000_0777);

        // Random back-to-back stream
        for (int i = 0; i < 100; i++) begin
            randomize_inputs();
            Reset = 0;
            Stall = ($urandom_range(0, 7) == 0);
            Flush = ($urandom_range(0, 9) == 0);
            step("random");
        end
        idle_inputs();

        // Drain with a bounded wait
        for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(negedge Clk);
        if (exp_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain: got %0d pending expectations, expected 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
